bounce_pulse_gen: RTL and testbench

Stimulus generator for the pulse-width/bounce measurement path. On a start request it drives a single output line through a programmable number of contact-bounce glitches and then one steady high pulse of programmed width. It then returns the line low and signals completion. It sits upstream of the bounce counter, on board or in simulation, so counter readings can be checked against known widths.

---
 rtl/bounce_pulse_gen.sv | 202 ++++++++++++++++++++
 tb/tb_bounce_pulse_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bounce_pulse_gen.sv
// Bounce/pulse stimulus generator: B contact-bounce glitches followed by one steady pulse of W cycles.
// Optional macro BOUNCE_LFSR_EN randomises each glitch phase length from a 16-bit LFSR.
module bounce_pulse_gen #(
    parameter int WIDTH_W  = 14,
    parameter int GLITCH_W = 8,
    parameter int BOUNCE_W = 4
) (
    input  logic                i_100MHZCLK,
    input  logic                i_RST,
    input  logic                i_START,
    input  logic [WIDTH_W-1:0]  i_WIDTH,
    input  logic [BOUNCE_W-1:0] i_BOUNCES,
    input  logic [GLITCH_W-1:0] i_GLITCH_LEN,
`ifdef BOUNCE_LFSR_EN
    output logic [15:0]         o_LFSR,
`endif
    output logic                o_SIGNAL,
    output logic                o_BUSY,
    output logic                o_DONE,
    output logic [WIDTH_W-1:0]  o_PHASE_CNT
);

    // Handshake: i_START is a request sampled only in IDLE; o_BUSY covers the whole pulse train,
    // o_DONE is a one-cycle strobe in FINISH, and requests seen while not in IDLE are dropped.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_G_HI   = 3'd1,
        S_G_LO   = 3'd2,
        S_STEADY = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_signal;
    logic                  r_busy;
    logic                  r_done;
    logic [WIDTH_W-1:0]    r_phase_cnt;
    logic [WIDTH_W-1:0]    r_width;
    logic [BOUNCE_W-1:0]   r_bounces;
    logic [GLITCH_W-1:0]   r_glitch_cfg;
    logic [GLITCH_W-1:0]   r_glen;

    logic                  w_signal;
    logic                  w_busy;
    logic                  w_done;
    logic [WIDTH_W-1:0]    w_phase_cnt;
    logic [WIDTH_W-1:0]    w_width;
    logic [BOUNCE_W-1:0]   w_bounces;
    logic [GLITCH_W-1:0]   w_glitch_cfg;
    logic [GLITCH_W-1:0]   w_glen;

    logic [GLITCH_W-1:0]   w_len_in_raw;
    logic [GLITCH_W-1:0]   w_len_cfg_raw;
    logic [GLITCH_W-1:0]   w_len_in;
    logic [GLITCH_W-1:0]   w_len_cfg;
    logic [WIDTH_W-1:0]    w_glen_ext;
    logic                  w_start_ok;

`ifdef BOUNCE_LFSR_EN
    logic [15:0]           r_lfsr;
    logic                  w_lfsr_fb;

    // Fibonacci taps 16,14,13,11 on a left-shifting register.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge i_100MHZCLK) begin
        if (i_RST) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_len_in_raw  = r_lfsr[GLITCH_W-1:0] & i_GLITCH_LEN;
    assign w_len_cfg_raw = r_lfsr[GLITCH_W-1:0] & r_glitch_cfg;
    assign o_LFSR        = r_lfsr;
`else
    assign w_len_in_raw  = i_GLITCH_LEN;
    assign w_len_cfg_raw = r_glitch_cfg;
`endif

    // A zero glitch length would never match the 1-based phase counter, so it becomes 1.
    assign w_len_in   = (w_len_in_raw  == '0) ? GLITCH_W'(1) : w_len_in_raw;
    assign w_len_cfg  = (w_len_cfg_raw == '0) ? GLITCH_W'(1) : w_len_cfg_raw;
    assign w_glen_ext = WIDTH_W'(r_glen);
    assign w_start_ok = i_START && (i_WIDTH != '0);

    always_ff @(posedge i_100MHZCLK) begin
        if (i_RST) begin
            r_state      <= S_IDLE;
            r_signal     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_phase_cnt  <= '0;
            r_width      <= '0;
            r_bounces    <= '0;
            r_glitch_cfg <= '0;
            r_glen       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_signal     <= w_signal;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_phase_cnt  <= w_phase_cnt;
            r_width      <= w_width;
            r_bounces    <= w_bounces;
            r_glitch_cfg <= w_glitch_cfg;
            r_glen       <= w_glen;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_signal     = r_signal;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_phase_cnt  = r_phase_cnt;
        w_width      = r_width;
        w_bounces    = r_bounces;
        w_glitch_cfg = r_glitch_cfg;
        w_glen       = r_glen;

        case (r_state)
            S_IDLE: begin
                w_signal = 1'b0;
                w_busy   = 1'b0;
                if (w_start_ok) begin
                    w_width      = i_WIDTH;
                    w_bounces    = i_BOUNCES;
                    w_glitch_cfg = i_GLITCH_LEN;
                    w_signal     = 1'b1;
                    w_busy       = 1'b1;
                    w_phase_cnt  = WIDTH_W'(1);
                    if (i_BOUNCES != '0) begin
                        w_state_nxt = S_G_HI;
                        w_glen      = w_len_in;
                    end else begin
                        w_state_nxt = S_STEADY;
                    end
                end
            end

            S_G_HI: begin
                if (r_phase_cnt == w_glen_ext) begin
                    w_state_nxt = S_G_LO;
                    w_signal    = 1'b0;
                    w_phase_cnt = WIDTH_W'(1);
                    w_bounces   = r_bounces - BOUNCE_W'(1);
                    w_glen      = w_len_cfg;
                end else begin
                    w_phase_cnt = r_phase_cnt + WIDTH_W'(1);
                end
            end

            S_G_LO: begin
                if (r_phase_cnt == w_glen_ext) begin
                    w_signal    = 1'b1;
                    w_phase_cnt = WIDTH_W'(1);
                    if (r_bounces != '0) begin
                        w_state_nxt = S_G_HI;
                        w_glen      = w_len_cfg;
                    end else begin
                        w_state_nxt = S_STEADY;
                    end
                end else begin
                    w_phase_cnt = r_phase_cnt + WIDTH_W'(1);
                end
            end

            S_STEADY: begin
                if (r_phase_cnt == r_width) begin
                    w_state_nxt = S_FINISH;
                    w_signal    = 1'b0;
                    w_busy      = 1'b0;
                    w_done      = 1'b1;
                end else begin
                    w_phase_cnt = r_phase_cnt + WIDTH_W'(1);
                end
            end

            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_signal    = 1'b0;
                w_busy      = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_signal    = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    assign o_SIGNAL    = r_signal;
    assign o_BUSY      = r_busy;
    assign o_DONE      = r_done;
    assign o_PHASE_CNT = r_phase_cnt;

endmodule

// File: tb/tb_bounce_pulse_gen.sv
// Bench for bounce_pulse_gen: the driver pushes the expected per-cycle output word for every edge,
// a monitor pops and compares one word per cycle just after the rising edge.
module tb_bounce_pulse_gen;

  localparam int WW = 14;
  localparam int GW = 8;
  localparam int BW = 4;
  localparam int EW = WW + 3;

  logic          clk;
  logic          i_rst;
  logic          i_start;
  logic [WW-1:0] i_width;
  logic [BW-1:0] i_bounces;
  logic [GW-1:0] i_glitch_len;
  logic          o_signal;
  logic          o_busy;
  logic          o_done;
  logic [WW-1:0] o_phase_cnt;
`ifdef BOUNCE_LFSR_EN
  logic [15:0]   o_lfsr;
`endif

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [WW-1:0] last_pc;
  int            n_checks;
  int            n_fail;

  bounce_pulse_gen #(.WIDTH_W(WW), .GLITCH_W(GW), .BOUNCE_W(BW)) dut (
    .i_100MHZCLK  (clk),
    .i_RST        (i_rst),
    .i_START      (i_start),
    .i_WIDTH      (i_width),
    .i_BOUNCES    (i_bounces),
    .i_GLITCH_LEN (i_glitch_len),
`ifdef BOUNCE_LFSR_EN
    .o_LFSR       (o_lfsr),
`endif
    .o_SIGNAL     (o_signal),
    .o_BUSY       (o_busy),
    .o_DONE       (o_done),
    .o_PHASE_CNT  (o_phase_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic sig, input logic busy, input logic done,
                                       input logic [WW-1:0] pc);
    return {sig, busy, done, pc};
  endfunction

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("o_SIGNAL",    32'(o_signal),    32'(mon_e[EW-1]));
      check("o_BUSY",      32'(o_busy),      32'(mon_e[EW-2]));
      check("o_DONE",      32'(o_done),      32'(mon_e[EW-3]));
      check("o_PHASE_CNT", 32'(o_phase_cnt), 32'(mon_e[WW-1:0]));
    end
  end

  // driver tasks: each one starts and ends at a falling edge
  task automatic idle(input int n, input bit start, input int width);
    for (int i = 0; i < n; i++) begin
      i_start = start;
      i_width = WW'(width);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, last_pc));
      @(negedge clk);
    end
  endtask

  task automatic reset_cycle();
    i_rst   = 1'b1;
    i_start = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, '0));
    @(negedge clk);
    i_rst   = 1'b0;
    last_pc = '0;
  endtask

  task automatic run(input int w, input int b, input int gl, input bit keep_start,
                     input bit scramble, input int abort_at);
    logic [EW-1:0] pat[$];
    int l;
    int n;
    l = (gl == 0) ? 1 : gl;
    for (int g = 0; g < b; g++) begin
      for (int i = 1; i <= l; i++) pat.push_back(mk(1'b1, 1'b1, 1'b0, WW'(i)));
      for (int i = 1; i <= l; i++) pat.push_back(mk(1'b0, 1'b1, 1'b0, WW'(i)));
    end
    for (int i = 1; i <= w; i++) pat.push_back(mk(1'b1, 1'b1, 1'b0, WW'(i)));
    pat.push_back(mk(1'b0, 1'b0, 1'b1, WW'(w)));
    n = (abort_at > 0 && abort_at < pat.size()) ? abort_at : pat.size();
    i_start      = 1'b1;
    i_width      = WW'(w);
    i_bounces    = BW'(b);
    i_glitch_len = GW'(gl);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back(pat[j]);
      @(negedge clk);
      i_start = keep_start;
      if (scramble) begin
        i_width      = WW'(100);
        i_bounces    = BW'($urandom);
        i_glitch_len = GW'($urandom);
      end
    end
    last_pc = WW'(w);
  endtask

  initial begin
    int rw;
    int rb;
    int rg;
    n_checks     = 0;
    n_fail       = 0;
    last_pc      = '0;
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_width      = '0;
    i_bounces    = '0;
    i_glitch_len = '0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, '0));
      @(negedge clk);
    end
    i_rst = 1'b0;
    idle(4, 1'b0, 0);

    run(10, 0, 0, 1'b0, 1'b0, 0);
    idle(3, 1'b0, 0);
    run(10, 2, 3, 1'b0, 1'b0, 0);
    idle(2, 1'b0, 0);
    run(4, 1, 0, 1'b0, 1'b0, 0);
    idle(2, 1'b0, 0);
    idle(4, 1'b1, 0);

    // start held high and config scrambled mid-run; the next run begins on the IDLE edge
    run(10, 2, 3, 1'b1, 1'b1, 0);
    idle(1, 1'b1, 100);
    run(100, 0, 0, 1'b0, 1'b0, 0);
    idle(2, 1'b0, 0);

    // reset in STEADY when the phase count is 5
    run(10, 0, 0, 1'b0, 1'b0, 5);
    reset_cycle();
    idle(2, 1'b0, 0);
    run(7, 1, 2, 1'b0, 1'b0, 0);
    idle(2, 1'b0, 0);

    for (int k = 0; k < 6; k++) begin
      rw = $urandom_range(40, 1);
      rb = $urandom_range(4, 0);
      rg = $urandom_range(5, 0);
      run(rw, rb, rg, 1'b0, 1'b0, 0);
      idle($urandom_range(3, 1), 1'b0, 0);
    end

    run(16383, 0, 0, 1'b0, 1'b0, 0);
    idle(2, 1'b0, 0);
    run(1, 15, 255, 1'b0, 1'b0, 0);
    idle(2, 1'b0, 0);

    @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
